// File: rtl/uart_reg_bridge_pkg.sv
// Shared constants and types for the UART command/register bridge.
// Holds opcodes, default status bytes, FSM state encoding and a fetch-state helper.
// No logic; imported by uart_reg_bridge.
package uart_reg_bridge_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_READ      = 8'h02;

  localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

  // Read response: status byte followed by four data bytes.
  localparam logic [2:0] RD_RESP_LAST = 3'd4;

  // Legacy-compatible encodings; the enum below is built on top of them.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OPC  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_BUS  = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_OPC  = ST_OPC,
    S_ADDR = ST_ADDR,
    S_DATA = ST_DATA,
    S_BUS  = ST_BUS,
    S_RESP = ST_RESP
  } state_e;

  // States in which the parser pulls bytes from the RX FIFO.
  function automatic logic is_fetch_state(state_e s);
    return (s == S_IDLE) || (s == S_ADDR) || (s == S_DATA);
  endfunction

endpackage

// File: rtl/fifo_byte_reader.sv
// Pops single bytes from a first-word-fall-after-read FIFO for any consumer.
// Latency: byte_valid one cycle after fifo_rden; at most one byte every 2 cycles.
// Backpressure: pops only while en is high and the FIFO is not empty.
//
// Ports:
//   CLK, RESETn     clock, synchronous active-low reset
//   en              consumer wants a byte this cycle
//   fifo_empty      FIFO empty flag
//   fifo_rden       FIFO pop strobe
//   fifo_din        FIFO read data (valid the cycle after fifo_rden)
//   rd_byte         captured byte, qualified by byte_valid
//   byte_valid      rd_byte holds a freshly popped byte this cycle
module fifo_byte_reader (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       en,
  input  logic       fifo_empty,
  output logic       fifo_rden,
  input  logic [7:0] fifo_din,
  output logic [7:0] rd_byte,
  output logic       byte_valid
);

  logic pending;

  // A pop in flight blocks the next one so the consumer sees the byte
  // and can change state before another is requested.
  assign fifo_rden  = en && !fifo_empty && !pending;
  assign byte_valid = pending;
  assign rd_byte    = fifo_din;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      pending <= 1'b0;
    end else begin
      pending <= fifo_rden;
    end
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// Host command responder: parses RX FIFO bytes into 32-bit register writes/reads, replies via TX FIFO.
// Latency: read response starts 3 cycles after the address byte is captured when the bus acks at once.
// Backpressure: RX bytes wait in the RX FIFO outside fetch states; TX_FIFO_FULL stalls the response.
//
// Optional feature: define UART_REG_BRIDGE_TIMEOUT_EN to discard commands whose
// bytes stop arriving for TIMEOUT_CYCLES clocks.
//
// Ports:
//   CLK, RESETn                           clock, synchronous active-low reset
//   RX_FIFO_EMPTY/RDEN/DIN                command byte source
//   TX_FIFO_FULL/WREN/DOUT                response byte sink
//   BUS_REQ/WE/ADDR/WDATA/RDATA/ACK       request/acknowledge register bus
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 48000,
  parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0] ERR_BYTE       = DEF_ERR_BYTE
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        RX_FIFO_EMPTY,
  output logic        RX_FIFO_RDEN,
  input  logic [7:0]  RX_FIFO_DIN,
  input  logic        TX_FIFO_FULL,
  output logic        TX_FIFO_WREN,
  output logic [7:0]  TX_FIFO_DOUT,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [7:0]  BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ACK
);

  state_e      state;
  logic [7:0]  opc_q;
  logic [1:0]  data_cnt;
  logic [2:0]  resp_cnt;
  logic        resp_err;
  logic [31:0] rdata_q;

  logic        rd_en;
  logic        byte_valid;
  logic [7:0]  rd_byte;
  logic        resp_last;
  logic        to_fire;
  logic [7:0]  tx_byte;

  // Reset gating keeps both FIFO strobes low while RESETn is asserted,
  // before the synchronous reset has taken the FSM back to IDLE.
  assign rd_en = RESETn && is_fetch_state(state);

  fifo_byte_reader u_reader (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .en         (rd_en),
    .fifo_empty (RX_FIFO_EMPTY),
    .fifo_rden  (RX_FIFO_RDEN),
    .fifo_din   (RX_FIFO_DIN),
    .rd_byte    (rd_byte),
    .byte_valid (byte_valid)
  );

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;
  logic            in_cmd;

  assign in_cmd = (state == S_ADDR) || (state == S_DATA);

  // Never abort with a pop in flight, otherwise the popped byte would land
  // in IDLE and be misread as an opcode.
  assign to_fire = in_cmd && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) &&
                   !RX_FIFO_RDEN && !byte_valid;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      to_cnt <= '0;
    end else if (in_cmd && !byte_valid && !to_fire) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign to_fire        = 1'b0;
`endif

  // Error and write responses are the status byte alone.
  assign resp_last = (resp_err || BUS_WE) ? (resp_cnt == 3'd0) : (resp_cnt == RD_RESP_LAST);

  always_comb begin
    tx_byte = 8'h00;
    if (state == S_RESP) begin
      case (resp_cnt)
        3'd0:    tx_byte = resp_err ? ERR_BYTE : ACK_BYTE;
        3'd1:    tx_byte = rdata_q[7:0];
        3'd2:    tx_byte = rdata_q[15:8];
        3'd3:    tx_byte = rdata_q[23:16];
        3'd4:    tx_byte = rdata_q[31:24];
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign TX_FIFO_WREN = RESETn && (state == S_RESP) && !TX_FIFO_FULL;
  assign TX_FIFO_DOUT = tx_byte;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state     <= S_IDLE;
      opc_q     <= 8'h00;
      data_cnt  <= 2'd0;
      resp_cnt  <= 3'd0;
      resp_err  <= 1'b0;
      rdata_q   <= 32'h0;
      BUS_REQ   <= 1'b0;
      BUS_WE    <= 1'b0;
      BUS_ADDR  <= 8'h00;
      BUS_WDATA <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (byte_valid) begin
            opc_q <= rd_byte;
            state <= S_OPC;
          end
        end
        S_OPC: begin
          data_cnt <= 2'd0;
          resp_cnt <= 3'd0;
          if (opc_q == OP_WRITE || opc_q == OP_READ) begin
            BUS_WE   <= (opc_q == OP_WRITE);
            resp_err <= 1'b0;
            state    <= S_ADDR;
          end else begin
            resp_err <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_ADDR: begin
          if (to_fire) begin
            state <= S_IDLE;
          end else if (byte_valid) begin
            BUS_ADDR <= rd_byte;
            state    <= BUS_WE ? S_DATA : S_BUS;
          end
        end
        S_DATA: begin
          if (to_fire) begin
            state <= S_IDLE;
          end else if (byte_valid) begin
            BUS_WDATA[{data_cnt, 3'b000} +: 8] <= rd_byte;
            data_cnt <= data_cnt + 2'd1;
            if (data_cnt == 2'd3) begin
              state <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // REQ is raised one cycle after entry; ACK only counts while REQ is up.
          if (!BUS_REQ) begin
            BUS_REQ <= 1'b1;
          end else if (BUS_ACK) begin
            BUS_REQ <= 1'b0;
            rdata_q <= BUS_RDATA;
            state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (TX_FIFO_WREN) begin
            if (resp_last) begin
              resp_cnt <= 3'd0;
              state    <= S_IDLE;
            end else begin
              resp_cnt <= resp_cnt + 3'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge with behavioural RX/TX FIFOs and an
// acknowledge-after-N bus responder. Expected values are hand-computed.
module tb_uart_reg_bridge;

  logic        CLK;
  logic        RESETn;
  logic        RX_FIFO_EMPTY;
  logic        RX_FIFO_RDEN;
  logic [7:0]  RX_FIFO_DIN;
  logic        TX_FIFO_FULL;
  logic        TX_FIFO_WREN;
  logic [7:0]  TX_FIFO_DOUT;
  logic        BUS_REQ;
  logic        BUS_WE;
  logic [7:0]  BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic [31:0] BUS_RDATA;
  logic        BUS_ACK;

  uart_reg_bridge #(.TIMEOUT_CYCLES(100)) dut (
    .CLK           (CLK),
    .RESETn        (RESETn),
    .RX_FIFO_EMPTY (RX_FIFO_EMPTY),
    .RX_FIFO_RDEN  (RX_FIFO_RDEN),
    .RX_FIFO_DIN   (RX_FIFO_DIN),
    .TX_FIFO_FULL  (TX_FIFO_FULL),
    .TX_FIFO_WREN  (TX_FIFO_WREN),
    .TX_FIFO_DOUT  (TX_FIFO_DOUT),
    .BUS_REQ       (BUS_REQ),
    .BUS_WE        (BUS_WE),
    .BUS_ADDR      (BUS_ADDR),
    .BUS_WDATA     (BUS_WDATA),
    .BUS_RDATA     (BUS_RDATA),
    .BUS_ACK       (BUS_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_log[$];
  int          cyc = 0;
  int          last_rden = 0;
  int          first_wren = 0;
  int          viol_rden = 0;
  int          viol_wren = 0;
  int          ack_len = 1;
  int          req_hi = 0;
  int          bus_n = 0;
  logic        last_we;
  logic [7:0]  last_addr;
  logic [31:0] last_wdata;
  int          last_req_len = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT outputs at the falling edge, then update the
  // behavioural FIFOs and bus responder just after the rising edge.
  task automatic step();
    logic pop;
    logic done;
    pop  = 1'b0;
    done = 1'b0;
    @(negedge CLK);
    cyc++;
    if (RX_FIFO_RDEN) begin
      if (RX_FIFO_EMPTY) viol_rden++;
      last_rden = cyc;
      pop = 1'b1;
    end
    if (TX_FIFO_WREN) begin
      if (TX_FIFO_FULL) viol_wren++;
      if (tx_log.size() == 0) first_wren = cyc;
      tx_log.push_back(TX_FIFO_DOUT);
    end
    if (BUS_REQ && BUS_ACK) begin
      bus_n++;
      last_we      = BUS_WE;
      last_addr    = BUS_ADDR;
      last_wdata   = BUS_WDATA;
      last_req_len = req_hi;
      done = 1'b1;
    end
    @(posedge CLK);
    #1;
    if (pop && rx_q.size() > 0) RX_FIFO_DIN = rx_q.pop_front();
    RX_FIFO_EMPTY = (rx_q.size() == 0);
    if (done) BUS_RDATA = ~BUS_RDATA;
    if (BUS_REQ) begin
      req_hi++;
      BUS_ACK = (req_hi == ack_len);
    end else begin
      req_hi  = 0;
      BUS_ACK = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    RX_FIFO_EMPTY = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (tx_log.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  function automatic logic [63:0] tx_pack();
    logic [63:0] v;
    v = '0;
    foreach (tx_log[i]) v = {v[55:0], tx_log[i]};
    return v;
  endfunction

  int b0;

  initial begin
    RESETn        = 1'b0;
    RX_FIFO_EMPTY = 1'b1;
    RX_FIFO_DIN   = 8'h00;
    TX_FIFO_FULL  = 1'b0;
    BUS_RDATA     = 32'h0;
    BUS_ACK       = 1'b0;
    repeat (3) step();
    chk("reset_outputs",
        {RX_FIFO_RDEN, TX_FIFO_WREN, BUS_REQ, BUS_WE, BUS_ADDR, BUS_WDATA, TX_FIFO_DOUT}, 64'h0);
    RESETn = 1'b1;
    repeat (2) step();

    // Write 01 10 EF BE AD DE
    tx_log.delete();
    b0 = bus_n;
    push(8'h01); push(8'h10); push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
    wait_tx(1, 200);
    repeat (3) step();
    chk("wr_bus_count", bus_n - b0, 1);
    chk("wr_bus_we", last_we, 1);
    chk("wr_bus_addr", last_addr, 8'h10);
    chk("wr_bus_wdata", last_wdata, 32'hDEADBEEF);
    chk("wr_tx_bytes", {tx_log.size(), tx_pack()}, {32'd1, 64'hA5});

    // Read 02 20, ack in 5th REQ cycle
    tx_log.delete();
    b0 = bus_n;
    ack_len   = 5;
    BUS_RDATA = 32'h12345678;
    push(8'h02); push(8'h20);
    wait_tx(5, 200);
    repeat (3) step();
    chk("rd5_bus", {bus_n - b0, 31'd0, last_we, last_addr}, {32'd1, 31'd0, 1'b0, 8'h20});
    chk("rd5_req_len", last_req_len, 5);
    chk("rd5_tx_bytes", {tx_log.size(), tx_pack()}, {32'd5, 64'hA5_78_56_34_12});

    // Read latency with immediate ack
    tx_log.delete();
    ack_len   = 1;
    BUS_RDATA = 32'h0BADC0DE;
    push(8'h02); push(8'h21);
    wait_tx(5, 200);
    repeat (3) step();
    chk("rd1_latency", first_wren - last_rden - 1, 3);
    chk("rd1_tx_bytes", {tx_log.size(), tx_pack()}, {32'd5, 64'hA5_DE_C0_AD_0B});

    // Unknown opcode followed by a read
    tx_log.delete();
    b0 = bus_n;
    ack_len   = 2;
    BUS_RDATA = 32'hA1B2C3D4;
    push(8'h7F); push(8'h02); push(8'h20);
    wait_tx(6, 300);
    repeat (3) step();
    chk("err_bus", {bus_n - b0, 31'd0, last_we}, {32'd1, 31'd0, 1'b0});
    chk("err_tx_bytes", {tx_log.size(), tx_pack()}, {32'd6, 64'hEE_A5_D4_C3_B2_A1});

    // TX full for 10 cycles mid read response
    tx_log.delete();
    ack_len   = 1;
    BUS_RDATA = 32'h12345678;
    push(8'h02); push(8'h20);
    wait_tx(2, 200);
    TX_FIFO_FULL = 1'b1;
    repeat (10) step();
    chk("full_hold_count", tx_log.size(), 2);
    TX_FIFO_FULL = 1'b0;
    wait_tx(5, 200);
    repeat (3) step();
    chk("full_tx_bytes", {tx_log.size(), tx_pack()}, {32'd5, 64'hA5_78_56_34_12});

    // Trickled write with empty gaps
    tx_log.delete();
    b0 = bus_n;
    begin
      logic [7:0] tb_bytes[6];
      int         gaps[6];
      tb_bytes = '{8'h01, 8'h10, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      gaps     = '{1, 20, 3, 7, 12, 5};
      for (int i = 0; i < 6; i++) begin
        repeat (gaps[i]) step();
        push(tb_bytes[i]);
      end
    end
    wait_tx(1, 200);
    repeat (3) step();
    chk("trk_bus", {bus_n - b0, 31'd0, last_we, last_addr, last_wdata},
        {32'd1, 31'd0, 1'b1, 8'h10, 32'hDEADBEEF});
    chk("trk_tx_bytes", {tx_log.size(), tx_pack()}, {32'd1, 64'hA5});

    // Stalled command: timeout build discards it, default build waits
    tx_log.delete();
    b0 = bus_n;
    push(8'h01); push(8'h10); push(8'hEF);
    repeat (150) step();
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    chk("to_nothing_sent", {bus_n - b0, tx_log.size()}, 64'h0);
    BUS_RDATA = 32'h12345678;
    push(8'h02); push(8'h20);
    wait_tx(5, 200);
    repeat (3) step();
    chk("to_read_bus", {bus_n - b0, 31'd0, last_we, last_addr}, {32'd1, 31'd0, 1'b0, 8'h20});
    chk("to_read_tx", {tx_log.size(), tx_pack()}, {32'd5, 64'hA5_78_56_34_12});
`else
    chk("nto_waiting", {bus_n - b0, tx_log.size()}, 64'h0);
    push(8'hBE); push(8'hAD); push(8'hDE);
    wait_tx(1, 200);
    repeat (3) step();
    chk("nto_write_bus", {bus_n - b0, 31'd0, last_we, last_wdata},
        {32'd1, 31'd0, 1'b1, 32'hDEADBEEF});
    chk("nto_write_tx", {tx_log.size(), tx_pack()}, {32'd1, 64'hA5});
`endif

    // Reset mid-command discards partial bytes
    tx_log.delete();
    push(8'h01); push(8'h10); push(8'hEF);
    repeat (10) step();
    RESETn = 1'b0;
    step();
    chk("rst_mid_outputs", {RX_FIFO_RDEN, TX_FIFO_WREN, BUS_REQ}, 3'b000);
    RESETn = 1'b1;
    BUS_RDATA = 32'h0BADC0DE;
    push(8'h02); push(8'h33);
    wait_tx(5, 200);
    repeat (3) step();
    chk("rst_mid_read", {last_addr, tx_pack()}, {8'h33, 64'hA5_DE_C0_AD_0B});

    // Reset in the same cycle as BUS_ACK: reset wins, no response
    tx_log.delete();
    ack_len = 3;
    push(8'h02); push(8'h20);
    begin
      int k;
      k = 0;
      while (!BUS_ACK && k < 100) begin
        step();
        k++;
      end
    end
    chk("rst_ack_seen", {BUS_REQ, BUS_ACK}, 2'b11);
    RESETn = 1'b0;
    step();
    RESETn = 1'b1;
    chk("rst_ack_req_low", BUS_REQ, 1'b0);
    repeat (20) step();
    chk("rst_ack_no_tx", tx_log.size(), 0);

    chk("rden_while_empty", viol_rden, 0);
    chk("wren_while_full", viol_wren, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
